sdes_round_ctrl: RTL and testbench

- Iterative S-DES encrypt/decrypt engine built around one shared F-function (fk) datapath.
- The fk datapath contains one switch_s0 and one switch_s1 instance, and the controller reuses it for both rounds.
- It sequences the key schedule (K1/K2 generation), IP, round 1, the half swap, round 2 and IP^-1, under a start/valid handshake.
- It sits between the board I/O wrapper (switches/keys/HEX display) and the S-box lookup modules.

---
 rtl/sdes_round_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_sdes_round_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdes_round_ctrl.sv
// sdes_round_ctrl: iterative S-DES encrypt/decrypt engine that reuses one fk datapath for both rounds.
// Optional macro SDES_KEY_CACHE_EN: reuse K1/K2 when the same key arrives again and skip the KEY state.
module sdes_round_ctrl #(
    parameter int PIPE_SBOX = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_decrypt,
    input  logic [9:0] i_key,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_valid,
    output logic [7:0] o_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_R1   = 3'd2,
        ST_R1W  = 3'd3,
        ST_R2   = 3'd4,
        ST_R2W  = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

    localparam logic PIPE_EN = (PIPE_SBOX != 32'sd0);

    // Permutation tables, written as bit selects: table entry i maps to bit (width - i).
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    // S0 lookup; row = outer bits, col = inner bits of the nibble.
    function automatic logic [1:0] switch_s0(input logic [3:0] n);
        case ({n[3], n[0], n[2], n[1]})
            4'd0:  return 2'd1;
            4'd1:  return 2'd0;
            4'd2:  return 2'd3;
            4'd3:  return 2'd2;
            4'd4:  return 2'd3;
            4'd5:  return 2'd2;
            4'd6:  return 2'd1;
            4'd7:  return 2'd0;
            4'd8:  return 2'd0;
            4'd9:  return 2'd2;
            4'd10: return 2'd1;
            4'd11: return 2'd3;
            4'd12: return 2'd3;
            4'd13: return 2'd1;
            4'd14: return 2'd3;
            4'd15: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] switch_s1(input logic [3:0] n);
        case ({n[3], n[0], n[2], n[1]})
            4'd0:  return 2'd0;
            4'd1:  return 2'd1;
            4'd2:  return 2'd2;
            4'd3:  return 2'd3;
            4'd4:  return 2'd2;
            4'd5:  return 2'd0;
            4'd6:  return 2'd1;
            4'd7:  return 2'd3;
            4'd8:  return 2'd3;
            4'd9:  return 2'd0;
            4'd10: return 2'd1;
            4'd11: return 2'd0;
            4'd12: return 2'd2;
            4'd13: return 2'd1;
            4'd14: return 2'd0;
            4'd15: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Returns {K1, K2}; K2 uses the cumulative 3-position rotation of each half.
    function automatic logic [15:0] key_sched(input logic [9:0] key);
        logic [9:0] p;
        logic [4:0] lh1, rh1, lh3, rh3;
        p   = p10(key);
        lh1 = {p[8:5], p[9]};
        rh1 = {p[3:0], p[4]};
        lh3 = {lh1[2:0], lh1[4:3]};
        rh3 = {rh1[2:0], rh1[4:3]};
        return {p8({lh1, rh1}), p8({lh3, rh3})};
    endfunction

    state_t     state_r;
    logic [9:0] key_r;
    logic [7:0] data_r;
    logic       dec_r;
    logic [7:0] rk_a_r;
    logic [7:0] rk_b_r;
    logic [3:0] l_r;
    logic [3:0] r_r;
    logic [3:0] sbox_r;
    logic       busy_r;
    logic       valid_r;
    logic [7:0] dout_r;

    logic [7:0] k1_s;
    logic [7:0] k2_s;
    logic [7:0] kround_s;
    logic [7:0] x_s;
    logic [3:0] sbox_s;
    logic [3:0] p4_in_s;
    logic [3:0] l_new_s;

`ifdef SDES_KEY_CACHE_EN
    logic [9:0] cache_key_r;
    logic [7:0] cache_k1_r;
    logic [7:0] cache_k2_r;
    logic       cache_v_r;
    logic       cache_hit_s;

    assign cache_hit_s = cache_v_r && (cache_key_r == i_key);
`endif

    // Shared fk datapath: round key follows the round being executed.
    assign {k1_s, k2_s} = key_sched(key_r);
    assign kround_s     = (state_r == ST_R1 || state_r == ST_R1W) ? rk_a_r : rk_b_r;
    assign x_s          = ep(r_r) ^ kround_s;
    assign sbox_s       = {switch_s0(x_s[7:4]), switch_s1(x_s[3:0])};
    assign p4_in_s      = PIPE_EN ? sbox_r : sbox_s;
    assign l_new_s      = l_r ^ p4(p4_in_s);

    // Control FSM together with the operand, round-state and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            key_r   <= 10'd0;
            data_r  <= 8'd0;
            dec_r   <= 1'b0;
            rk_a_r  <= 8'd0;
            rk_b_r  <= 8'd0;
            l_r     <= 4'd0;
            r_r     <= 4'd0;
            sbox_r  <= 4'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            dout_r  <= 8'd0;
`ifdef SDES_KEY_CACHE_EN
            cache_key_r <= 10'd0;
            cache_k1_r  <= 8'd0;
            cache_k2_r  <= 8'd0;
            cache_v_r   <= 1'b0;
`endif
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        key_r  <= i_key;
                        data_r <= i_data;
                        dec_r  <= i_decrypt;
                        busy_r <= 1'b1;
`ifdef SDES_KEY_CACHE_EN
                        if (cache_hit_s) begin
                            rk_a_r     <= i_decrypt ? cache_k2_r : cache_k1_r;
                            rk_b_r     <= i_decrypt ? cache_k1_r : cache_k2_r;
                            {l_r, r_r} <= ip(i_data);
                            state_r    <= ST_R1;
                        end else begin
                            state_r <= ST_KEY;
                        end
`else
                        state_r <= ST_KEY;
`endif
                    end
                end
                ST_KEY: begin
                    rk_a_r     <= dec_r ? k2_s : k1_s;
                    rk_b_r     <= dec_r ? k1_s : k2_s;
                    {l_r, r_r} <= ip(data_r);
`ifdef SDES_KEY_CACHE_EN
                    cache_key_r <= key_r;
                    cache_k1_r  <= k1_s;
                    cache_k2_r  <= k2_s;
                    cache_v_r   <= 1'b1;
`endif
                    state_r <= ST_R1;
                end
                ST_R1: begin
                    if (PIPE_EN) begin
                        sbox_r  <= sbox_s;
                        state_r <= ST_R1W;
                    end else begin
                        {l_r, r_r} <= {r_r, l_new_s};
                        state_r    <= ST_R2;
                    end
                end
                ST_R1W: begin
                    {l_r, r_r} <= {r_r, l_new_s};
                    state_r    <= ST_R2;
                end
                ST_R2: begin
                    if (PIPE_EN) begin
                        sbox_r  <= sbox_s;
                        state_r <= ST_R2W;
                    end else begin
                        // Result is registered on entry to FIN so o_valid/o_data are flop outputs there.
                        l_r     <= l_new_s;
                        dout_r  <= ip_inv({l_new_s, r_r});
                        valid_r <= 1'b1;
                        state_r <= ST_FIN;
                    end
                end
                ST_R2W: begin
                    l_r     <= l_new_s;
                    dout_r  <= ip_inv({l_new_s, r_r});
                    valid_r <= 1'b1;
                    state_r <= ST_FIN;
                end
                ST_FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = busy_r;
    assign o_valid = valid_r;
    assign o_data  = dout_r;

endmodule

// File: tb/tb_sdes_round_ctrl.sv
// Randomized bench for sdes_round_ctrl: two instances (PIPE_SBOX=0 and 1) share the stimulus and are
// checked every cycle against a table-driven S-DES reference and a transaction-level timing model.
module tb_sdes_round_ctrl;

    typedef int tbl_t [10];
    typedef int sbox_t [4][4];

    localparam tbl_t P10_T = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam tbl_t P8_T  = '{6, 3, 7, 4, 8, 5, 10, 9, 1, 1};
    localparam tbl_t IP_T  = '{2, 6, 3, 1, 4, 8, 5, 7, 1, 1};
    localparam tbl_t IPI_T = '{4, 1, 3, 5, 7, 2, 8, 6, 1, 1};
    localparam tbl_t EP_T  = '{4, 1, 2, 3, 2, 3, 4, 1, 1, 1};
    localparam tbl_t P4_T  = '{2, 4, 3, 1, 1, 1, 1, 1, 1, 1};
    localparam sbox_t S0_T = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    localparam sbox_t S1_T = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    logic       clk;
    logic       rst;
    logic       start;
    logic       dec;
    logic [9:0] key;
    logic [7:0] din;
    logic [1:0] busy;
    logic [1:0] valid;
    logic [7:0] dout [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Timing model state per instance (index 0: PIPE_SBOX=0, index 1: PIPE_SBOX=1)
    int         base_lat [2] = '{4, 6};
    bit         m_act [2];
    int         m_acc [2];
    int         m_done [2];
    int         m_free [2];
    logic [7:0] m_res [2];
    logic [7:0] m_exp [2];
    bit         m_cv [2];
    logic [9:0] m_ck [2];

    sdes_round_ctrl #(.PIPE_SBOX(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_decrypt(dec), .i_key(key), .i_data(din),
        .o_busy(busy[0]), .o_valid(valid[0]), .o_data(dout[0])
    );

    sdes_round_ctrl #(.PIPE_SBOX(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_decrypt(dec), .i_key(key), .i_data(din),
        .o_busy(busy[1]), .o_valid(valid[1]), .o_data(dout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Output bit j (from MSB) takes input position t[j], counted 1-based from the MSB of an inw-bit value.
    function automatic logic [9:0] permute(input logic [9:0] v, input int inw, input int outw, input tbl_t t);
        logic [9:0] r;
        r = '0;
        for (int j = 0; j < outw; j++) r[outw - 1 - j] = v[inw - t[j]];
        return r;
    endfunction

    function automatic logic [4:0] rotl5(input logic [4:0] v, input int n);
        int t;
        t = int'(v);
        return 5'(((t << n) | (t >> (5 - n))) & 31);
    endfunction

    // Returns {L xor F(R,k), R}
    function automatic logic [7:0] ref_fk(input logic [7:0] lr, input logic [7:0] k);
        logic [9:0] t;
        logic [7:0] x;
        logic [3:0] s;
        int row;
        int col;
        t   = permute({6'd0, lr[3:0]}, 4, 8, EP_T);
        x   = t[7:0] ^ k;
        row = 2 * int'(x[7]) + int'(x[4]);
        col = 2 * int'(x[6]) + int'(x[5]);
        s[3:2] = 2'(S0_T[row][col]);
        row = 2 * int'(x[3]) + int'(x[0]);
        col = 2 * int'(x[2]) + int'(x[1]);
        s[1:0] = 2'(S1_T[row][col]);
        t = permute({6'd0, s}, 4, 4, P4_T);
        return {lr[7:4] ^ t[3:0], lr[3:0]};
    endfunction

    function automatic logic [7:0] ref_sdes(input logic [9:0] k, input logic [7:0] d, input logic de);
        logic [9:0] p;
        logic [9:0] t;
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] st;
        p  = permute(k, 10, 10, P10_T);
        t  = permute({rotl5(p[9:5], 1), rotl5(p[4:0], 1)}, 10, 8, P8_T);
        k1 = t[7:0];
        t  = permute({rotl5(p[9:5], 3), rotl5(p[4:0], 3)}, 10, 8, P8_T);
        k2 = t[7:0];
        t  = permute({2'd0, d}, 8, 8, IP_T);
        st = ref_fk(t[7:0], de ? k2 : k1);
        st = {st[3:0], st[7:4]};
        st = ref_fk(st, de ? k1 : k2);
        t  = permute({2'd0, st}, 8, 8, IPI_T);
        return t[7:0];
    endfunction

    // Apply the inputs present at the coming edge to the transaction model.
    task automatic model_edge();
        bit hit;
        int lat;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d]  = 1'b0;
                m_free[d] = cyc + 1;
                m_exp[d]  = 8'd0;
                m_cv[d]   = 1'b0;
            end else if (start && cyc >= m_free[d]) begin
                hit = 1'b0;
`ifdef SDES_KEY_CACHE_EN
                hit     = m_cv[d] && (m_ck[d] == key);
                m_cv[d] = 1'b1;
                m_ck[d] = key;
`endif
                lat       = base_lat[d] - (hit ? 1 : 0);
                m_act[d]  = 1'b1;
                m_acc[d]  = cyc;
                m_done[d] = cyc + lat - 1;
                m_free[d] = cyc + lat + 1;
                m_res[d]  = ref_sdes(key, din, dec);
            end
        end
    endtask

    task automatic check_cycle();
        logic eb;
        logic ev;
        for (int d = 0; d < 2; d++) begin
            eb = m_act[d] && cyc >= m_acc[d] && cyc <= m_done[d];
            ev = m_act[d] && cyc == m_done[d];
            if (ev) m_exp[d] = m_res[d];
            chk_eq($sformatf("busy%0d", d), 32'(busy[d]), 32'(eb));
            chk_eq($sformatf("valid%0d", d), 32'(valid[d]), 32'(ev));
            chk_eq($sformatf("data%0d", d), 32'(dout[d]), 32'(m_exp[d]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
        cyc++;
    endtask

    task automatic drive(input logic s, input logic [9:0] k, input logic [7:0] d, input logic de);
        start = s;
        key   = k;
        din   = d;
        dec   = de;
    endtask

    task automatic op(input logic [9:0] k, input logic [7:0] d, input logic de);
        drive(1'b1, k, d, de);
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d]  = 1'b0;
            m_free[d] = 0;
            m_exp[d]  = 8'd0;
            m_cv[d]   = 1'b0;
            m_ck[d]   = 10'd0;
        end
        rst = 1'b1;
        drive(1'b0, 10'd0, 8'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Known-answer vectors
        op(10'b1010000010, 8'b10010111, 1'b0);
        chk_eq("kat_enc0", 32'(dout[0]), 32'(8'b00111000));
        chk_eq("kat_enc1", 32'(dout[1]), 32'(8'b00111000));
        op(10'b1010000010, 8'b00111000, 1'b1);
        chk_eq("kat_dec0", 32'(dout[0]), 32'(8'b10010111));
        chk_eq("kat_dec1", 32'(dout[1]), 32'(8'b10010111));

        // Random operations; operand churn and stray starts while busy
        for (int n = 0; n < 40; n++) begin
            drive(1'b1, 10'($urandom_range(1023, 0)), 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
            step();
            for (int g = 0; g < int'($urandom_range(8, 0)); g++) begin
                drive(($urandom_range(3, 0) == 0), 10'($urandom_range(1023, 0)),
                      8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
                step();
            end
        end

        // i_start held high with alternating vectors
        for (int i = 0; i < 36; i++) begin
            if (i % 2 == 0) drive(1'b1, 10'h2A5, 8'h3C, 1'b0);
            else            drive(1'b1, 10'h15A, 8'hC3, 1'b1);
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Reset in the middle of an operation, then a clean operation
        drive(1'b1, 10'h0F3, 8'h5A, 1'b0);
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("abort_busy0", 32'(busy[0]), 32'(1'b0));
        chk_eq("abort_data1", 32'(dout[1]), 32'(8'h00));
        op(10'h0F3, 8'h5A, 1'b0);

        // Same key twice then a different key (shorter latency only with the key cache)
        op(10'h3C9, 8'h11, 1'b0);
        op(10'h3C9, 8'hEE, 1'b1);
        op(10'h3C9, 8'h42, 1'b0);
        op(10'h1B7, 8'h42, 1'b0);
        op(10'h1B7, 8'h99, 1'b1);

        for (int i = 0; i < 4; i++) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
